// File: rtl/ntt_coef_loader_if.sv
// Stream and core-load bundles for ntt_coef_loader.
// Stream handshake: a beat transfers on a rising edge where s_valid and s_ready are both high;
// s_data must be stable while s_valid is high, and ready never depends combinationally on valid.
interface ntt_stream_if;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;

    modport master (output s_valid, s_data, input s_ready);
    modport slave  (input s_valid, s_data, output s_ready);
endinterface

interface ntt_core_if #(parameter int AW = 8);
    logic          core_rst;
    logic          start;
    logic          mode;
    logic          we;
    logic [AW-1:0] address_ina;
    logic [AW-1:0] address_inb;
    logic [15:0]   data_ina;
    logic [15:0]   data_inb;
    logic          core_done;

    modport master (output core_rst, start, mode, we, address_ina, address_inb,
                    data_ina, data_inb, input core_done);
    modport slave  (input core_rst, start, mode, we, address_ina, address_inb,
                    data_ina, data_inb, output core_done);
endinterface

// File: rtl/ntt_coef_loader.sv
// Streams one polynomial of packed coefficient pairs into the NTT core RAM, reducing each
// coefficient mod Q, then releases the core and waits for its done level.
module ntt_coef_loader #(
    parameter int Q     = 3329,
    parameter int BEATS = 64,
    parameter int AW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           go,
    input  logic           mode_in,
    ntt_stream_if.slave    s_if,
    ntt_core_if.master     c_if,
    output logic           busy,
    output logic           job_done,
    output logic           coef_err,
    output logic [2:0]     dbg_state
);
    localparam int KW = $clog2(BEATS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_LOAD   = 3'd2,
        S_SETTLE = 3'd3,
        S_RUN    = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic            mode_q, mode_d;
    logic            we_q, we_d;
    logic            coef_err_q, coef_err_d;
    logic            job_done_q, job_done_d;
    logic [AW-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic [15:0]     data_a_q, data_a_d, data_b_q, data_b_d;
    logic            beat_acc;
    logic            last_beat;
    logic [16:0]     red_a, red_b;

    // Returns {out_of_range, reduced value}; anything at or above 2Q is forced to zero.
    function automatic logic [16:0] reduce(input logic [15:0] x);
        logic [16:0] xe;
        xe = {1'b0, x};
        if (xe >= 17'(2 * Q))
            return {1'b1, 16'd0};
        else if (xe >= 17'(Q))
            return {1'b0, 16'(xe - 17'(Q))};
        return {1'b0, x};
    endfunction

    assign red_a     = reduce(s_if.s_data[15:0]);
    assign red_b     = reduce(s_if.s_data[31:16]);
    assign last_beat = (k_q == KW'(BEATS - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Done is only honoured in RUN so a level left over from the previous job cannot end this one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (go) state_d = S_CLR;
            S_CLR:    state_d = S_LOAD;
            S_LOAD:   if (beat_acc && last_beat) state_d = S_SETTLE;
            S_SETTLE: state_d = S_RUN;
            S_RUN:    if (c_if.core_done) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        s_if.s_ready  = (state_q == S_LOAD);
        c_if.core_rst = (state_q == S_CLR);
        c_if.start    = (state_q == S_CLR) || (state_q == S_LOAD) || (state_q == S_SETTLE);
        busy          = (state_q != S_IDLE);
        beat_acc      = (state_q == S_LOAD) && s_if.s_valid;
        dbg_state     = state_q;
    end

    always_comb begin
        k_d        = k_q;
        mode_d     = mode_q;
        coef_err_d = coef_err_q;
        addr_a_d   = addr_a_q;
        addr_b_d   = addr_b_q;
        data_a_d   = data_a_q;
        data_b_d   = data_b_q;
        we_d       = beat_acc;
        job_done_d = (state_q == S_RUN) && c_if.core_done;
        if (state_q == S_IDLE) begin
            k_d = '0;
            if (go) begin
                mode_d     = mode_in;
                coef_err_d = 1'b0;
            end
        end
        if (beat_acc) begin
            addr_a_d   = AW'({k_q, 1'b0});
            addr_b_d   = AW'({k_q, 1'b1});
            data_a_d   = red_a[15:0];
            data_b_d   = red_b[15:0];
            coef_err_d = coef_err_q | red_a[16] | red_b[16];
            k_d        = k_q + KW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q        <= '0;
            mode_q     <= 1'b0;
            we_q       <= 1'b0;
            coef_err_q <= 1'b0;
            job_done_q <= 1'b0;
            addr_a_q   <= '0;
            addr_b_q   <= '0;
            data_a_q   <= '0;
            data_b_q   <= '0;
        end else begin
            k_q        <= k_d;
            mode_q     <= mode_d;
            we_q       <= we_d;
            coef_err_q <= coef_err_d;
            job_done_q <= job_done_d;
            addr_a_q   <= addr_a_d;
            addr_b_q   <= addr_b_d;
            data_a_q   <= data_a_d;
            data_b_q   <= data_b_d;
        end
    end

    assign c_if.mode        = mode_q;
    assign c_if.we          = we_q;
    assign c_if.address_ina = addr_a_q;
    assign c_if.address_inb = addr_b_q;
    assign c_if.data_ina    = data_a_q;
    assign c_if.data_inb    = data_b_q;
    assign coef_err         = coef_err_q;
    assign job_done         = job_done_q;
endmodule

// File: tb/tb_ntt_coef_loader.sv
// Randomized bench for ntt_coef_loader: a scoreboard of expected RAM writes is filled as beats
// are offered and drained by a monitor whenever the loader pulses we.
module tb_ntt_coef_loader;
    localparam int Q     = 3329;
    localparam int BEATS = 64;
    localparam int AW    = 8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go;
    logic       mode_in;
    logic       busy;
    logic       job_done;
    logic       coef_err;
    logic [2:0] dbg_state;

    ntt_stream_if           sif ();
    ntt_core_if #(.AW(AW))  cif ();

    ntt_coef_loader #(.Q(Q), .BEATS(BEATS), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .go        (go),
        .mode_in   (mode_in),
        .s_if      (sif),
        .c_if      (cif),
        .busy      (busy),
        .job_done  (job_done),
        .coef_err  (coef_err),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;
    int          wr_cnt = 0;
    int          beat;
    int          job_w0;
    int          clr_cyc;
    logic        exp_ready;
    logic        exp_mode;
    logic        exp_err;
    logic [47:0] exp_q[$];
    logic [47:0] last_exp = '0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int ref_reduce(input int x);
        if (x < Q)     return x;
        if (x < 2 * Q) return x - Q;
        return 0;
    endfunction

    function automatic logic [15:0] rand_coef();
        if ($urandom_range(0, 7) == 0) return 16'($urandom);
        return 16'($urandom_range(0, 2 * Q - 1));
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            last_exp = '0;
        end else if (cif.we) begin
            wr_cnt++;
            chk("start_at_we", 48'(cif.start), 48'(1));
            if (exp_q.size() == 0) begin
                chk("we_without_beat", 48'(cif.we), 48'(0));
            end else begin
                last_exp = exp_q.pop_front();
                chk("write", {cif.address_ina, cif.address_inb, cif.data_ina, cif.data_inb}, last_exp);
            end
        end else begin
            chk("hold", {cif.address_ina, cif.address_inb, cif.data_ina, cif.data_inb}, last_exp);
        end
    end

    // ---------------- driver tasks ----------------
    // One clock: check the pre-edge view, record any beat the loader should take, advance.
    task automatic tick();
        logic [15:0] a, b;
        @(negedge clk);
        chk("s_ready", 48'(sif.s_ready), 48'(exp_ready));
        chk("mode", 48'(cif.mode), 48'(exp_mode));
        chk("coef_err", 48'(coef_err), 48'(exp_err));
        if (sif.s_valid && exp_ready) begin
            a = sif.s_data[15:0];
            b = sif.s_data[31:16];
            exp_q.push_back({AW'(2 * beat), AW'(2 * beat + 1),
                             16'(ref_reduce(int'(a))), 16'(ref_reduce(int'(b)))});
            if (int'(a) >= 2 * Q || int'(b) >= 2 * Q) exp_err = 1'b1;
            beat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"},  48'(sif.s_ready), 48'(0));
        chk({tag, "_core_rst"}, 48'(cif.core_rst), 48'(0));
        chk({tag, "_start"},    48'(cif.start), 48'(0));
        chk({tag, "_mode"},     48'(cif.mode), 48'(0));
        chk({tag, "_we"},       48'(cif.we), 48'(0));
        chk({tag, "_addr"},     48'({cif.address_ina, cif.address_inb}), 48'(0));
        chk({tag, "_data"},     48'({cif.data_ina, cif.data_inb}), 48'(0));
        chk({tag, "_busy"},     48'(busy), 48'(0));
        chk({tag, "_job_done"}, 48'(job_done), 48'(0));
        chk({tag, "_coef_err"}, 48'(coef_err), 48'(0));
        chk({tag, "_state"},    48'(dbg_state), 48'(0));
    endtask

    task automatic start_job(input logic m);
        go = 1'b1;
        mode_in = m;
        sif.s_valid = 1'b0;
        exp_ready = 1'b0;
        tick();
        go = 1'b0;
        exp_mode = m;
        exp_err = 1'b0;
        beat = 0;
        job_w0 = wr_cnt;
        clr_cyc = cyc_cnt;
        chk("busy_clr", 48'(busy), 48'(1));
        chk("core_rst_clr", 48'(cif.core_rst), 48'(1));
        chk("start_clr", 48'(cif.start), 48'(1));
        mode_in = ~m;
        sif.s_valid = 1'b1;
        sif.s_data = $urandom;
        tick();
        chk("core_rst_load", 48'(cif.core_rst), 48'(0));
        chk("start_load", 48'(cif.start), 48'(1));
        exp_ready = 1'b1;
    endtask

    // vpat: 0 continuous, 1 valid 1,0,0 repeating, 2 random; dsel: 0 index data, 1 random, 2 boundary
    task automatic load_beats(input int n, input int vpat, input int dsel, input bit noise);
        int cyc;
        cyc = 0;
        while (beat < n && cyc < 2000) begin
            case (vpat)
                0:       sif.s_valid = 1'b1;
                1:       sif.s_valid = (cyc % 3 == 0);
                default: sif.s_valid = 1'($urandom_range(0, 1));
            endcase
            if (dsel == 0)
                sif.s_data = {16'(2 * beat + 1), 16'(2 * beat)};
            else if (dsel == 2 && beat == 0)
                sif.s_data = {16'd3329, 16'd3328};
            else if (dsel == 2 && beat == 1)
                sif.s_data = {16'd6658, 16'd6657};
            else if (dsel == 2 && beat == 2)
                sif.s_data = {16'd0, 16'd65535};
            else
                sif.s_data = {rand_coef(), rand_coef()};
            if (noise) begin
                cif.core_done = 1'b1;
                go = 1'($urandom_range(0, 1));
                mode_in = 1'($urandom_range(0, 1));
            end
            tick();
            cyc++;
        end
        if (beat < n) chk("load_timeout", 48'(beat), 48'(n));
        go = 1'b0;
        if (beat >= BEATS) exp_ready = 1'b0;
    endtask

    task automatic finish_job(input int run_wait, input int exp_fall);
        sif.s_valid = 1'b1;
        sif.s_data = $urandom;
        cif.core_done = 1'b0;
        go = 1'b0;
        chk("start_settle", 48'(cif.start), 48'(1));
        chk("busy_settle", 48'(busy), 48'(1));
        tick();
        chk("start_run", 48'(cif.start), 48'(0));
        if (exp_fall != 0) chk("start_fall_cycle", 48'(cyc_cnt - clr_cyc), 48'(exp_fall));
        for (int i = 0; i < run_wait; i++) begin
            go = 1'($urandom_range(0, 1));
            mode_in = 1'($urandom_range(0, 1));
            tick();
            chk("busy_run", 48'(busy), 48'(1));
            chk("start_run_hold", 48'(cif.start), 48'(0));
            chk("job_done_run", 48'(job_done), 48'(0));
        end
        go = 1'b0;
        cif.core_done = 1'b1;
        tick();
        cif.core_done = 1'b0;
        sif.s_valid = 1'b0;
        chk("job_done_pulse", 48'(job_done), 48'(1));
        chk("busy_after_done", 48'(busy), 48'(0));
        chk("writes_per_job", 48'(wr_cnt - job_w0), 48'(BEATS));
        chk("scoreboard_drained", 48'(exp_q.size()), 48'(0));
        tick();
        chk("job_done_single", 48'(job_done), 48'(0));
        chk("busy_idle", 48'(busy), 48'(0));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        go = 1'b0;
        mode_in = 1'b0;
        sif.s_valid = 1'b0;
        sif.s_data = '0;
        cif.core_done = 1'b0;
        exp_ready = 1'b0;
        exp_mode = 1'b0;
        exp_err = 1'b0;
        beat = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("por");
        rst_n = 1'b1;
        tick();
        tick();

        // Abort mid-load: reset lands between edges and must clear everything at once.
        start_job(1'b1);
        load_beats(10, 0, 1, 1'b0);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset("mid_load");
        exp_q.delete();
        exp_ready = 1'b0;
        exp_mode = 1'b0;
        exp_err = 1'b0;
        sif.s_valid = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start_job(1'b0);
        load_beats(BEATS, 0, 0, 1'b0);
        finish_job(5, 66);

        start_job(1'b1);
        load_beats(BEATS, 1, 1, 1'b0);
        finish_job(3, 0);

        start_job(1'b0);
        load_beats(BEATS, 0, 2, 1'b1);
        finish_job(200, 0);
        tick();

        start_job(1'b1);
        load_beats(BEATS, 2, 1, 1'b1);
        finish_job(int'($urandom_range(1, 20)), 0);

        // A go raised right after a job is taken on the next IDLE edge.
        go = 1'b1;
        mode_in = 1'b0;
        tick();
        go = 1'b0;
        chk("restart_busy", 48'(busy), 48'(1));
        chk("restart_core_rst", 48'(cif.core_rst), 48'(1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ntt_coef_loader.md
# ntt_coef_loader

Upstream feeder for the NTT/INTT core wrapper. The block accepts packed coefficient pairs over a valid/ready stream and reduces each coefficient modulo q. It generates the core's load-phase controls: reset, `start`, `we`, dual addresses and data, and mode. It then releases the core into computation and waits for the core's `done` before accepting the next polynomial.

## Interface

Parameters:
- `Q`, 3329: modulus; one conditional subtraction per coefficient.
- `BEATS`, 64: stream beats per polynomial; each beat carries 2 coefficients, so 128 coefficients total.
- `AW`, 8: core RAM address width.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `go` in 1: start one load+compute job; sampled only in IDLE.
- `mode_in` in 1: 0 = NTT, 1 = INTT; captured when `go` is accepted.
- `s_valid` in 1: stream beat valid.
- `s_data` in 32: `[15:0]` = coefficient 2k, `[31:16]` = coefficient 2k+1.
- `s_ready` out 1: beat accepted when `s_valid & s_ready`.
- `core_rst` out 1: active-high reset pulse to the core.
- `start` out 1: core load-phase select; high selects external RAM addresses.
- `mode` out 1: captured `mode_in`, held stable for the whole job.
- `we` out 1: core RAM write enable, both ports.
- `address_ina` out AW: equals 2k.
- `address_inb` out AW: equals 2k+1.
- `data_ina` out 16: reduced coefficient 2k.
- `data_inb` out 16: reduced coefficient 2k+1.
- `core_done` in 1: core `done` level.
- `busy` out 1: high in every state except IDLE.
- `job_done` out 1: one-cycle pulse at job end.
- `coef_err` out 1: sticky flag; some coefficient in the current job was ≥ 2Q.

## Operation

- **States:** IDLE, CLR, LOAD, SETTLE, RUN.
- **IDLE:**
  - `go=1` → CLR.
  - Captures `mode_in` into `mode`, clears `coef_err` and the beat counter `k`.
- **CLR (1 cycle):**
  - `core_rst=1`, `start=1`.
  - → LOAD.
- **LOAD:**
  - `start=1`, `s_ready=1`.
  - Each accepted beat registers `we=1`, addresses {2k, 2k+1}, and the reduced data, then increments `k`.
  - Cycles without an accepted beat register `we=0`; addresses and data hold their last values.
  - Acceptance of beat `k=BEATS-1` → SETTLE; `s_ready` drops the cycle after that beat.
- **SETTLE (1 cycle):**
  - `start=1`, `we=0`; lets the final RAM write complete.
  - → RUN.
- **RUN:**
  - `start=0`; waits for `core_done=1`.
  - On `core_done=1`: `job_done=1` for one cycle, → IDLE.
- **Reduction, per 16-bit coefficient x:**
  - x < Q → x.
  - Q ≤ x < 2Q → x−Q.
  - x ≥ 2Q → 0, and set `coef_err`.
- Unsigned compare; results always fit in 12 bits and are zero-extended to 16.
- `go` outside IDLE is ignored. `s_valid` outside LOAD is ignored; no beat is consumed.
- `core_done` seen in CLR, LOAD or SETTLE is ignored; stale done from a previous job must not end the current one.
- `mode` never changes while `busy=1`.

## Timing

- **Reset values (`rst_n=0`, asynchronous):**
  - State IDLE.
  - `s_ready=0`, `core_rst=0`, `start=0`, `mode=0`, `we=0`.
  - Addresses 0, data 0.
  - `busy=0`, `job_done=0`, `coef_err=0`.
- Reset mid-job aborts immediately to these values. No partial beats are retained; the next `go` restarts at k=0.
- **Beat latency:** beat accepted at edge t → `we`, addresses and data valid from edge t+1 for exactly one cycle.
- **Throughput:** one beat per cycle. Minimum job is 1 (CLR) + 64 (LOAD) + 1 (SETTLE) cycles before `start` falls.
- `go` at edge t → `busy=1` and `core_rst=1` from t+1; `start=1` from t+1.
- The last `we` pulse (addresses 126/127) coincides with the SETTLE cycle. `start` falls the following cycle.
- `core_done` high at edge t in RUN → `job_done=1` during t+1 and `busy=0` from t+1.
- `go` held high continuously: a new job starts the cycle after returning to IDLE, i.e. one idle cycle between jobs.

## Test plan

- **Reset defaults:** assert `rst_n=0` mid-LOAD after 10 beats → all outputs at reset values within the same cycle. After release, `go` plus 64 beats loads addresses 0..127 from scratch.
- **Back-to-back load, NTT:** `go` with `mode_in=0`, then 64 beats with `s_valid` continuously high, `s_data={2k+1, 2k}` → 64 consecutive `we` pulses with addresses (0,1)…(126,127) and identical data. `start` falls 66 cycles after CLR. `mode=0` throughout.
- **Throttled stream, INTT:** `mode_in=1`; `s_valid` toggles 1,0,0,1… → `we` only after accepted beats; addresses and data hold during gaps; exactly 64 writes total; `mode=1`.
- **Reduction boundaries:** coefficients 3328, 3329, 6657, 6658, 65535 → data 3328, 0, 3328, 0, 0. `coef_err` rises on the 6658 beat and stays high until the next accepted `go`.
- **Done handshake:** `core_done` held high during LOAD → ignored. `core_done` pulsed 200 cycles into RUN → single-cycle `job_done`, `busy=0` the next cycle.
- **Ignored inputs:** `go` pulses during LOAD and RUN, and `s_valid=1` in RUN → no state change, `s_ready=0` in RUN, `mode` unchanged.
